wb_sram_pgas: RTL and testbench



---
 rtl/wb_sram_pgas_pkg.sv | 34 +++
 rtl/wb_sram_pgas_if.sv | 25 ++
 rtl/wb_sram_pgas_sram_sp.sv | 33 +++
 rtl/wb_sram_pgas.sv | 139 +++++++++++++
 tb/tb_wb_sram_pgas.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_sram_pgas_pkg.sv
// Shared constants for the PGAS tile SRAM slave: Wishbone cycle/burst encodings,
// controller states and the burst address step.
package wb_sram_pgas_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    // Only the bits under the mask increment; linear bursts use the memory-size mask.
    function automatic logic [29:0] burst_next(input logic [29:0] cur,
                                               input logic [1:0]  bte,
                                               input logic [29:0] lin_mask);
        logic [29:0] mask;
        case (bte)
            BTE_WRAP4:  mask = 30'd3;
            BTE_WRAP8:  mask = 30'd7;
            BTE_WRAP16: mask = 30'd15;
            default:    mask = lin_mask;
        endcase
        return (cur & ~mask) | ((cur + 30'd1) & mask);
    endfunction

endpackage

// File: rtl/wb_sram_pgas_if.sv
// Wishbone B3 bus bundle between the tile LSU (master) and the SRAM slave.
interface wb_sram_pgas_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_sram_pgas_sram_sp.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
module sram_sp #(
    parameter int unsigned DEPTH    = 8192,
    parameter int unsigned AW       = 13,
    parameter string       MEM_FILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Output register only loads on reads, so the bus data holds across writes and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rdata_q <= '0;
        else if (en && (we == 4'b0))   rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/wb_sram_pgas.sv
// Wishbone B3 SRAM slave for the PGAS memory tile: classic cycles plus linear and
// wrapping incrementing bursts at one word per clock, with error termination out of range.
module wb_sram_pgas
    import wb_sram_pgas_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 32'h8000,
    parameter string       MEM_FILE = "sram.vmem"
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_sram_pgas_if.slave   wb
);
    localparam int unsigned WORDS    = MEM_SIZE / 4;
    localparam int unsigned AW       = $clog2(WORDS);
    localparam logic [29:0] LIN_MASK = 30'(WORDS - 1);
    localparam logic [31:0] LIMIT    = 32'(MEM_SIZE);

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [29:0] baddr_q, baddr_d;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    logic        req, beat_done, bus_oor, nxt_oor;
    logic [29:0] bus_word, nxt;
    logic        unused_adr_lsb;

    assign unused_adr_lsb = ^wb.wb_adr_i[1:0];
    assign bus_word  = wb.wb_adr_i[31:2];
    assign bus_oor   = (wb.wb_adr_i >= LIMIT);
    assign nxt       = burst_next(baddr_q, wb.wb_bte_i, LIN_MASK);
    assign nxt_oor   = ({nxt, 2'b00} >= LIMIT);
    assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign beat_done = wb.wb_cyc_i & wb.wb_stb_i & ack_q;

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        baddr_d  = baddr_q;
        ram_en   = 1'b0;
        ram_we   = 4'b0;
        ram_addr = bus_word[AW-1:0];
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bus_oor) begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        ack_d   = 1'b1;
                        ram_en  = ~wb.wb_we_i;
                        baddr_d = bus_word;
                        state_d = (wb.wb_cti_i == CTI_INCR) ? ST_BURST : ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (beat_done && wb.wb_we_i) begin
                    ram_en = 1'b1;
                    ram_we = wb.wb_sel_i;
                end
            end
            ST_BURST: begin
                if (!wb.wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (beat_done) begin
                    if (wb.wb_we_i) begin
                        ram_en   = 1'b1;
                        ram_we   = wb.wb_sel_i;
                        ram_addr = baddr_q[AW-1:0];
                    end
                    // Pre-acknowledge the next beat so the burst streams without wait states.
                    if (wb.wb_cti_i == CTI_INCR) begin
                        baddr_d = nxt;
                        if (nxt_oor) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ack_d = 1'b1;
                            if (!wb.wb_we_i) begin
                                ram_en   = 1'b1;
                                ram_addr = nxt[AW-1:0];
                            end
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (req) begin
                    // Resume after a strobe gap from the held beat address.
                    ack_d = 1'b1;
                    if (!wb.wb_we_i) begin
                        ram_en   = 1'b1;
                        ram_addr = baddr_q[AW-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            baddr_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            baddr_q <= baddr_d;
        end
    end

    sram_sp #(
        .DEPTH    (WORDS),
        .AW       (AW),
        .MEM_FILE (MEM_FILE)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wb.wb_dat_i),
        .rdata (ram_rdata)
    );

    assign wb.wb_dat_o = ram_rdata;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_rty_o = 1'b0;
endmodule

// File: tb/tb_wb_sram_pgas.sv
// Directed bench for wb_sram_pgas: classic, byte-lane, burst, gap, range-error and reset cases.
module tb_wb_sram_pgas;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_sram_pgas_if wb_if();

    wb_sram_pgas #(
        .MEM_SIZE (32'h8000),
        .MEM_FILE ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_if)
    );

    logic [31:0] abuf [16];
    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    int nack, nerr, stalls, nboth;
    logic tail;
    int compared = 0;
    int mismatched = 0;

    task automatic bus_idle();
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_cti_i = 3'b000;
        wb_if.wb_bte_i = 2'b00;
        wb_if.wb_adr_i = '0;
        wb_if.wb_dat_i = '0;
        wb_if.wb_sel_i = '0;
    endtask

    task automatic drive_beat(input int i, input int n, input logic we, input logic burst,
                              input logic [1:0] bte, input logic [3:0] sel);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = we;
        wb_if.wb_sel_i = sel;
        wb_if.wb_bte_i = bte;
        wb_if.wb_adr_i = abuf[i];
        wb_if.wb_dat_i = wbuf[i];
        wb_if.wb_cti_i = !burst ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
    endtask

    // Master model: samples on the falling edge, advances beats just after the rising edge.
    task automatic wb_xfer(input logic we, input logic burst, input logic [1:0] bte,
                           input int n, input logic [3:0] sel, input int gap_at);
        int  i;
        bit  done;
        i = 0; done = 0; nack = 0; nerr = 0; stalls = 0; tail = 1'b0;
        @(negedge clk);
        drive_beat(0, n, we, burst, bte, sel);
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (wb_if.wb_ack_o && wb_if.wb_err_o) nboth++;
            if (wb_if.wb_err_o && wb_if.wb_stb_i) begin
                nerr++;
                @(posedge clk); #1;
                tail = wb_if.wb_ack_o | wb_if.wb_err_o;
                bus_idle();
                done = 1;
            end else if (wb_if.wb_ack_o && wb_if.wb_stb_i) begin
                rbuf[i] = wb_if.wb_dat_o;
                nack++;
                i++;
                @(posedge clk); #1;
                if (i == n) begin
                    bus_idle();
                    done = 1;
                end else begin
                    if (i == gap_at) begin
                        wb_if.wb_stb_i = 1'b0;
                        @(posedge clk); #1;
                    end
                    drive_beat(i, n, we, burst, bte, sel);
                end
            end else if (wb_if.wb_stb_i) begin
                stalls++;
            end
        end
        if (!done) bus_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (wb_if.wb_ack_o !== 1'b0) begin mismatched++; $display("FAIL reset_ack: got %b want 0", wb_if.wb_ack_o); end
        compared++; if (wb_if.wb_err_o !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", wb_if.wb_err_o); end
        compared++; if (wb_if.wb_dat_o !== 32'h0) begin mismatched++; $display("FAIL reset_dat: got %h want 00000000", wb_if.wb_dat_o); end
        compared++; if (wb_if.wb_rty_o !== 1'b0) begin mismatched++; $display("FAIL reset_rty: got %b want 0", wb_if.wb_rty_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst_write();
        for (int k = 0; k < 12; k++) begin
            abuf[k] = 32'(4 * k);
            wbuf[k] = 32'hC0DE_0000 | 32'(4 * k);
        end
        wb_xfer(1'b1, 1'b1, 2'b00, 12, 4'hF, -1);
        compared++; if (nack !== 12) begin mismatched++; $display("FAIL bwrite_acks: got %0d want 12", nack); end
        compared++; if (stalls !== 0) begin mismatched++; $display("FAIL bwrite_stalls: got %0d want 0", stalls); end
    endtask

    task automatic test_classic();
        abuf[0] = 32'h10; wbuf[0] = 32'hDEADBEEF;
        wb_xfer(1'b1, 1'b0, 2'b00, 1, 4'hF, -1);
        compared++; if (nack !== 1 || stalls !== 0) begin mismatched++; $display("FAIL classic_write_ack: got acks=%0d stalls=%0d want 1/0", nack, stalls); end
        wb_xfer(1'b0, 1'b0, 2'b00, 1, 4'hF, -1);
        compared++; if (nack !== 1 || stalls !== 0) begin mismatched++; $display("FAIL classic_read_ack: got acks=%0d stalls=%0d want 1/0", nack, stalls); end
        compared++; if (rbuf[0] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL classic_read_data: got %h want deadbeef", rbuf[0]); end
    endtask

    task automatic test_byte_write();
        abuf[0] = 32'h10; wbuf[0] = 32'h0000AB00;
        wb_xfer(1'b1, 1'b0, 2'b00, 1, 4'b0010, -1);
        wbuf[0] = 32'h0;
        wb_xfer(1'b0, 1'b0, 2'b00, 1, 4'hF, -1);
        compared++; if (rbuf[0] !== 32'hDEADABEF) begin mismatched++; $display("FAIL byte_write: got %h want deadabef", rbuf[0]); end
    endtask

    task automatic test_linear_read();
        logic [31:0] exp [4] = '{32'hC0DE0020, 32'hC0DE0024, 32'hC0DE0028, 32'hC0DE002C};
        for (int k = 0; k < 4; k++) begin abuf[k] = 32'h20 + 32'(4 * k); wbuf[k] = '0; end
        wb_xfer(1'b0, 1'b1, 2'b00, 4, 4'hF, -1);
        compared++; if (nack !== 4 || stalls !== 0) begin mismatched++; $display("FAIL linear_timing: got acks=%0d stalls=%0d want 4/0", nack, stalls); end
        for (int k = 0; k < 4; k++) begin
            compared++; if (rbuf[k] !== exp[k]) begin mismatched++; $display("FAIL linear_beat%0d: got %h want %h", k, rbuf[k], exp[k]); end
        end
    endtask

    task automatic test_wrap4();
        logic [31:0] adr [4] = '{32'h0C, 32'h00, 32'h04, 32'h08};
        logic [31:0] exp [4] = '{32'hC0DE000C, 32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008};
        for (int k = 0; k < 4; k++) begin abuf[k] = adr[k]; wbuf[k] = '0; end
        wb_xfer(1'b0, 1'b1, 2'b01, 4, 4'hF, -1);
        compared++; if (nack !== 4 || stalls !== 0) begin mismatched++; $display("FAIL wrap4_timing: got acks=%0d stalls=%0d want 4/0", nack, stalls); end
        for (int k = 0; k < 4; k++) begin
            compared++; if (rbuf[k] !== exp[k]) begin mismatched++; $display("FAIL wrap4_beat%0d: got %h want %h", k, rbuf[k], exp[k]); end
        end
    endtask

    task automatic test_wrap8();
        logic [31:0] adr [8] = '{32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        logic [31:0] exp [8] = '{32'hC0DE0018, 32'hC0DE001C, 32'hC0DE0000, 32'hC0DE0004,
                                 32'hC0DE0008, 32'hC0DE000C, 32'hDEADABEF, 32'hC0DE0014};
        for (int k = 0; k < 8; k++) begin abuf[k] = adr[k]; wbuf[k] = '0; end
        wb_xfer(1'b0, 1'b1, 2'b10, 8, 4'hF, -1);
        compared++; if (nack !== 8) begin mismatched++; $display("FAIL wrap8_acks: got %0d want 8", nack); end
        for (int k = 0; k < 8; k++) begin
            compared++; if (rbuf[k] !== exp[k]) begin mismatched++; $display("FAIL wrap8_beat%0d: got %h want %h", k, rbuf[k], exp[k]); end
        end
    endtask

    task automatic test_gap();
        for (int k = 0; k < 4; k++) begin abuf[k] = 32'(4 * k); wbuf[k] = '0; end
        wb_xfer(1'b0, 1'b1, 2'b00, 4, 4'hF, 2);
        compared++; if (nack !== 4 || stalls !== 1) begin mismatched++; $display("FAIL gap_timing: got acks=%0d stalls=%0d want 4/1", nack, stalls); end
        compared++; if (rbuf[2] !== 32'hC0DE0008) begin mismatched++; $display("FAIL gap_resume_data: got %h want c0de0008", rbuf[2]); end
        compared++; if (rbuf[3] !== 32'hC0DE000C) begin mismatched++; $display("FAIL gap_last_data: got %h want c0de000c", rbuf[3]); end
    endtask

    task automatic test_range();
        abuf[0] = 32'h2C; wbuf[0] = '0;
        wb_xfer(1'b0, 1'b0, 2'b00, 1, 4'hF, -1);
        abuf[0] = 32'h8000;
        wb_xfer(1'b0, 1'b0, 2'b00, 1, 4'hF, -1);
        compared++; if (nerr !== 1 || nack !== 0) begin mismatched++; $display("FAIL oor_read: got err=%0d ack=%0d want 1/0", nerr, nack); end
        compared++; if (tail !== 1'b0) begin mismatched++; $display("FAIL oor_err_width: got %b want 0 one cycle after err", tail); end
        compared++; if (wb_if.wb_dat_o !== 32'hC0DE002C) begin mismatched++; $display("FAIL oor_dat_hold: got %h want c0de002c", wb_if.wb_dat_o); end
        abuf[0] = 32'h8004; wbuf[0] = 32'h12345678;
        wb_xfer(1'b1, 1'b0, 2'b00, 1, 4'hF, -1);
        compared++; if (nerr !== 1 || nack !== 0) begin mismatched++; $display("FAIL oor_write: got err=%0d ack=%0d want 1/0", nerr, nack); end
        abuf[0] = 32'h04; wbuf[0] = '0;
        wb_xfer(1'b0, 1'b0, 2'b00, 1, 4'hF, -1);
        compared++; if (rbuf[0] !== 32'hC0DE0004) begin mismatched++; $display("FAIL oor_no_write: got %h want c0de0004", rbuf[0]); end
    endtask

    task automatic test_reset_midburst();
        for (int k = 0; k < 8; k++) begin abuf[k] = 32'(4 * k); wbuf[k] = '0; end
        @(negedge clk);
        drive_beat(0, 8, 1'b0, 1'b1, 2'b00, 4'hF);
        @(posedge clk); #1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            drive_beat(k, 8, 1'b0, 1'b1, 2'b00, 4'hF);
        end
        compared++; if (wb_if.wb_ack_o !== 1'b1) begin mismatched++; $display("FAIL midburst_ack: got %b want 1", wb_if.wb_ack_o); end
        rst_n = 1'b0;
        #1;
        compared++; if (wb_if.wb_ack_o !== 1'b0) begin mismatched++; $display("FAIL rst_mid_ack: got %b want 0", wb_if.wb_ack_o); end
        compared++; if (wb_if.wb_err_o !== 1'b0) begin mismatched++; $display("FAIL rst_mid_err: got %b want 0", wb_if.wb_err_o); end
        compared++; if (wb_if.wb_dat_o !== 32'h0) begin mismatched++; $display("FAIL rst_mid_dat: got %h want 00000000", wb_if.wb_dat_o); end
        @(negedge clk);
        bus_idle();
        rst_n = 1'b1;
        abuf[0] = 32'h0;
        wb_xfer(1'b0, 1'b0, 2'b00, 1, 4'hF, -1);
        compared++; if (nack !== 1 || rbuf[0] !== 32'hC0DE0000) begin mismatched++; $display("FAIL post_reset_read: got ack=%0d data=%h want 1/c0de0000", nack, rbuf[0]); end
        compared++; if (nboth !== 0) begin mismatched++; $display("FAIL ack_err_overlap: got %0d want 0", nboth); end
    endtask

    initial begin
        nboth = 0;
        bus_idle();
        test_reset();
        test_burst_write();
        test_classic();
        test_byte_write();
        test_linear_read();
        test_wrap4();
        test_wrap8();
        test_gap();
        test_range();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule
